comparador_secuencial: RTL
==========================

# comparador_secuencial

Parametrised, registered successor to the team's combinational 8-bit signed comparator. It accepts a stream of operand pairs over a valid/ready handshake and returns one registered equal/greater/less result per pair. Optionally, it accumulates per-frame counts of each outcome. It sits between a sample source and any consumer that needs both per-sample decisions and frame statistics.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥2).
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.
- FRAME, 16, samples per statistics frame (≥2).
- CW, $clog2(FRAME+1), width of the count outputs (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of all state.
- in_valid  in  1  operand pair a/b valid.
- in_ready  out  1  block can accept a pair this cycle.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b.
- out_valid  out  1  registered result valid.
- out_ready  in  1  consumer takes the result this cycle.
- igual  out  1  a == b.
- mayor  out  1  a > b.
- menor  out  1  a < b.
- frame_done  out  1  one-cycle pulse when a frame closes.
- cnt_igual, cnt_mayor, cnt_menor  out  CW each  outcome counts of the last completed frame.
- idx  out  CW  number of samples accepted in the current frame, 0..FRAME-1.

## Operation
- Accept: a pair is accepted on a rising edge where in_valid && in_ready && !clear.
- Flow control: in_ready = !clear && (!out_valid || out_ready). This gives a 1-deep output register with full throughput under continuous out_ready.
- Compare: on accept, igual/mayor/menor load the compare result of a and b. The comparison is signed or unsigned per SIGNED. Exactly one of the three flags is 1 while out_valid = 1. All three are 0 when out_valid = 0.
- Output hold: out_valid sets on accept. It clears on out_valid && out_ready with no accept in the same cycle. If both occur, out_valid stays 1 and the result register takes the new value.
- Frame counting: each accept increments idx and the running counter that matches the outcome.
- Frame close: on the accept that brings the frame to FRAME samples:
  - Running counts, including that sample, are copied to cnt_*.
  - Running counters and idx return to 0.
  - frame_done pulses.
- Count range: counts never exceed FRAME, so no saturation logic is needed. cnt_igual + cnt_mayor + cnt_menor == FRAME after every frame_done.
- clear:
  - Drops out_valid, zeroes result flags, idx, running counters and cnt_*.
  - Forces frame_done to 0.
  - Any pair presented in that cycle is not accepted.
- Reset: every output is 0 except in_ready, which is 1 one cycle after rst_n rises with clear low. Reset may be asserted at any point, including mid-frame or with out_valid pending; all state is lost.

## Timing
- Latency: a pair accepted at edge N appears with out_valid = 1 from edge N until it is consumed.
- Throughput: one pair per cycle when out_ready stays 1.
- Backpressure: with out_ready = 0 and out_valid = 1, in_ready is 0 and the result holds stable.
- frame_done is high for exactly the one cycle after the closing edge. It coincides with out_valid for the closing sample, and cnt_* update at that same edge.
- Frame counting follows accepts, not consumption: frame_done can assert while the closing result is still stalled at the output.

## Configuration
- COMPARADOR_CONTADORES_EN defined: frame counting, idx, cnt_* and frame_done behave as above.
- Not defined: counter logic is omitted. cnt_*, idx and frame_done are tied to 0, and the per-sample compare and handshake are unchanged.

## Test plan
- Signed wrap, WIDTH=8, SIGNED=1: a=8'h80, b=8'h01 -> menor=1, igual=0, mayor=0, one cycle after accept.
- Unsigned wrap, same values with SIGNED=0 -> mayor=1.
- Backpressure: stream 4 pairs with out_ready low for 3 cycles after the first accept -> in_ready=0 for those 3 cycles, the first result holds, and no pair is lost or duplicated (results in order).
- Frame counting, FRAME=4: pairs (3,3), (5,2), (-1,0), (7,7) streamed continuously -> frame_done one cycle after the 4th accept, with cnt_igual=2, cnt_mayor=1, cnt_menor=1 and idx=0.
- clear mid-frame: clear after 2 of 4 accepts -> out_valid=0 and idx=0. The next frame needs 4 fresh accepts before frame_done.
- Async reset: rst_n low mid-frame with out_valid=1 -> all outputs 0 immediately; in_ready=1 one cycle after release.
- Macro off: repeat the frame-counting stimulus -> frame_done, idx and cnt_* stay 0, and compare results are identical.

Source files
------------

// File: rtl/comparador_secuencial.sv
// Registered signed/unsigned comparator with valid/ready handshake and optional per-frame outcome counters.
// Define COMPARADOR_CONTADORES_EN to build the frame statistics (idx, cnt_*, frame_done); otherwise they are tied to 0.
module comparador_secuencial #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1,
  parameter int FRAME  = 16,
  parameter int CW     = $clog2(FRAME + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             igual,
  output logic             mayor,
  output logic             menor,
  output logic             frame_done,
  output logic [CW-1:0]    cnt_igual,
  output logic [CW-1:0]    cnt_mayor,
  output logic [CW-1:0]    cnt_menor,
  output logic [CW-1:0]    idx
);

  logic r_rstDone;
  logic r_outValid;
  logic r_igual;
  logic r_mayor;
  logic r_menor;

  logic w_accept;
  logic w_eq;
  logic w_gt;
  logic w_lt;

  assign w_eq = (a == b);
  assign w_gt = SIGNED ? ($signed(a) > $signed(b)) : (a > b);
  assign w_lt = SIGNED ? ($signed(a) < $signed(b)) : (a < b);

  // in_ready stays low until the first clock edge after reset release
  assign in_ready = r_rstDone && !clear && (!r_outValid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstDone <= 1'b0;
    end else begin
      r_rstDone <= 1'b1;
    end
  end

  // A new accept wins over consumption, so the output register never bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_igual    <= 1'b0;
      r_mayor    <= 1'b0;
      r_menor    <= 1'b0;
    end else if (clear) begin
      r_outValid <= 1'b0;
      r_igual    <= 1'b0;
      r_mayor    <= 1'b0;
      r_menor    <= 1'b0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_igual    <= w_eq;
      r_mayor    <= w_gt;
      r_menor    <= w_lt;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
      r_igual    <= 1'b0;
      r_mayor    <= 1'b0;
      r_menor    <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign igual     = r_igual;
  assign mayor     = r_mayor;
  assign menor     = r_menor;

`ifdef COMPARADOR_CONTADORES_EN
  logic [CW-1:0] r_idx;
  logic [CW-1:0] r_runIgual;
  logic [CW-1:0] r_runMayor;
  logic [CW-1:0] r_runMenor;
  logic [CW-1:0] r_cntIgual;
  logic [CW-1:0] r_cntMayor;
  logic [CW-1:0] r_cntMenor;
  logic          r_frameDone;

  logic [CW-1:0] w_incIgual;
  logic [CW-1:0] w_incMayor;
  logic [CW-1:0] w_incMenor;

  assign w_incIgual = r_runIgual + {{(CW-1){1'b0}}, w_eq};
  assign w_incMayor = r_runMayor + {{(CW-1){1'b0}}, w_gt};
  assign w_incMenor = r_runMenor + {{(CW-1){1'b0}}, w_lt};

  // Counting follows accepts, so a frame can close while its last result is still stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_runIgual  <= '0;
      r_runMayor  <= '0;
      r_runMenor  <= '0;
      r_cntIgual  <= '0;
      r_cntMayor  <= '0;
      r_cntMenor  <= '0;
      r_frameDone <= 1'b0;
    end else if (clear) begin
      r_idx       <= '0;
      r_runIgual  <= '0;
      r_runMayor  <= '0;
      r_runMenor  <= '0;
      r_cntIgual  <= '0;
      r_cntMayor  <= '0;
      r_cntMenor  <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (w_accept) begin
        if (r_idx == CW'(FRAME - 1)) begin
          r_cntIgual  <= w_incIgual;
          r_cntMayor  <= w_incMayor;
          r_cntMenor  <= w_incMenor;
          r_runIgual  <= '0;
          r_runMayor  <= '0;
          r_runMenor  <= '0;
          r_idx       <= '0;
          r_frameDone <= 1'b1;
        end else begin
          r_runIgual  <= w_incIgual;
          r_runMayor  <= w_incMayor;
          r_runMenor  <= w_incMenor;
          r_idx       <= r_idx + CW'(1);
        end
      end
    end
  end

  assign idx        = r_idx;
  assign cnt_igual  = r_cntIgual;
  assign cnt_mayor  = r_cntMayor;
  assign cnt_menor  = r_cntMenor;
  assign frame_done = r_frameDone;
`else
  assign idx        = '0;
  assign cnt_igual  = '0;
  assign cnt_mayor  = '0;
  assign cnt_menor  = '0;
  assign frame_done = 1'b0;
`endif

endmodule
